// File: rtl/vectored_irq_controller_if.sv
// CPU-side request/acknowledge bundle of the vectored interrupt controller.
// The controller drives irq/vector/grant_id; the CPU returns ack.
interface vectored_irq_controller_if #(
  parameter int I_ADDR_WIDTH = 10
);
  logic                    irq;
  logic                    ack;
  logic [I_ADDR_WIDTH-1:0] vector;
  logic [4:0]              grant_id;

  modport master (
    output irq,
    output vector,
    output grant_id,
    input  ack
  );

  modport slave (
    input  irq,
    input  vector,
    input  grant_id,
    output ack
  );
endinterface

// File: rtl/vectored_irq_controller.sv
// Vectored interrupt controller: edge/level capture, fixed or round-robin
// arbitration and a committed IDLE/REQUEST/ACKED handshake with the CPU.
module vectored_irq_controller #(
  parameter int CHANNELS      = 8,
  parameter int I_ADDR_WIDTH  = 10,
  parameter int VECTOR_BASE   = 1,
  parameter int VECTOR_STRIDE = 1,
  parameter int ROUND_ROBIN   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_lines,
  input  logic [CHANNELS-1:0] edge_sel,
  input  logic [CHANNELS-1:0] mask,
  input  logic                global_en,
  output logic [CHANNELS-1:0] pending,
  output logic                spurious_ack,
  vectored_irq_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    ACKED   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CHANNELS-1:0]     prev_q, pend_q, pend_d;
  logic [4:0]              gid_q, gid_d;
  logic [4:0]              last_q, last_d;
  logic [I_ADDR_WIDTH-1:0] vec_q, vec_d, vcalc;
  logic                    irq_q, irq_d;
  logic                    spur_q, spur_d;
  logic [CHANNELS-1:0]     cand;
  logic [4:0]              win;
  logic                    ack_req;

  function automatic logic [4:0] fixed_pick(
    input logic [CHANNELS-1:0] c
  );
    logic [4:0] w;
    w = '0;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (c[i]) w = 5'(i);
    return w;
  endfunction

  // Rotating search starting just after the previous winner
  function automatic logic [4:0] rr_pick(
    input logic [CHANNELS-1:0] c,
    input logic [4:0]          last
  );
    logic [4:0]          w;
    logic                found;
    logic [5:0]          idx;
    logic [CHANNELS-1:0] sh;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, last} + 6'd1 + 6'(k);
      if (idx >= 6'(CHANNELS)) idx = idx - 6'(CHANNELS);
      sh = c >> idx;
      if (!found && sh[0]) begin
        w     = idx[4:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign ack_req = (state_q == REQUEST) && bus.ack;
  assign cand    = pend_q & mask;

  always_comb begin
    win = '0;
    if (ROUND_ROBIN != 0) win = rr_pick(cand, last_q);
    else                  win = fixed_pick(cand);
  end

  assign vcalc = I_ADDR_WIDTH'(VECTOR_BASE + int'(win) * VECTOR_STRIDE);

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (edge_sel[i])
        pend_d[i] = (irq_lines[i] & ~prev_q[i]) |
                    (pend_q[i] & ~(ack_req && (gid_q == 5'(i))));
      else
        pend_d[i] = irq_lines[i];
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    vec_d   = vec_q;
    unique case (state_q)
      IDLE: begin
        if (global_en && (|cand)) begin
          state_d = REQUEST;
          gid_d   = win;
          vec_d   = vcalc;
        end
      end
      REQUEST: if (bus.ack) state_d = ACKED;
      ACKED:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_d  = (state_d == REQUEST);
    last_d = ack_req ? gid_q : last_q;
    spur_d = spur_q | (bus.ack && (state_q != REQUEST));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prev_q  <= '0;
      pend_q  <= '0;
      gid_q   <= '0;
      vec_q   <= '0;
      irq_q   <= 1'b0;
      spur_q  <= 1'b0;
      last_q  <= 5'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      prev_q  <= irq_lines;
      pend_q  <= pend_d;
      gid_q   <= gid_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
      spur_q  <= spur_d;
      last_q  <= last_d;
    end
  end

  assign bus.irq      = irq_q;
  assign bus.vector   = vec_q;
  assign bus.grant_id = gid_q;
  assign pending      = pend_q;
  assign spurious_ack = spur_q;

endmodule

// File: tb/tb_vectored_irq_controller.sv
// Directed bench: fixed-priority, round-robin and wrapping-vector instances
// of the vectored interrupt controller.
module tb_vectored_irq_controller;

  logic       clk;
  logic       reset;
  logic [7:0] lines, esel, msk;
  logic       gen;
  logic [7:0] rr_lines, rr_esel, rr_msk;
  logic       rr_gen;
  logic [7:0] pend_f, pend_r, pend_w;
  logic       spur_f, spur_r, spur_w;
  int         errs;
  int         checks;

  vectored_irq_controller_if #(.I_ADDR_WIDTH(10)) bf ();
  vectored_irq_controller_if #(.I_ADDR_WIDTH(10)) br ();
  vectored_irq_controller_if #(.I_ADDR_WIDTH(10)) bw ();

  vectored_irq_controller u_fix (
    .clk(clk), .reset(reset), .irq_lines(lines), .edge_sel(esel),
    .mask(msk), .global_en(gen), .pending(pend_f),
    .spurious_ack(spur_f), .bus(bf)
  );

  vectored_irq_controller #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset), .irq_lines(rr_lines), .edge_sel(rr_esel),
    .mask(rr_msk), .global_en(rr_gen), .pending(pend_r),
    .spurious_ack(spur_r), .bus(br)
  );

  vectored_irq_controller #(
    .I_ADDR_WIDTH(10), .VECTOR_BASE(1020), .VECTOR_STRIDE(2)
  ) u_wrap (
    .clk(clk), .reset(reset), .irq_lines(lines), .edge_sel(esel),
    .mask(msk), .global_en(gen), .pending(pend_w),
    .spurious_ack(spur_w), .bus(bw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   got;
    logic seen;
    errs = 0; checks = 0;
    reset = 1'b0;
    lines = '0; esel = 8'hFF; msk = 8'hFF; gen = 1'b1;
    rr_lines = '0; rr_esel = 8'h00; rr_msk = 8'hFF; rr_gen = 1'b1;
    bf.ack = 1'b0; br.ack = 1'b0; bw.ack = 1'b0;
    cyc(2);
    chk("rst_irq", 32'(bf.irq), 0);
    chk("rst_vec", 32'(bf.vector), 0);
    chk("rst_gid", 32'(bf.grant_id), 0);
    chk("rst_pend", 32'(pend_f), 0);
    chk("rst_spur", 32'(spur_f), 0);
    reset = 1'b1;
    cyc(1);

    // edge on ch3
    lines[3] = 1'b1;
    cyc(1);
    chk("ch3_pend", 32'(pend_f), 32'h08);
    chk("ch3_irq_early", 32'(bf.irq), 0);
    cyc(1);
    chk("ch3_irq", 32'(bf.irq), 1);
    chk("ch3_gid", 32'(bf.grant_id), 3);
    chk("ch3_vec", 32'(bf.vector), 4);
    chk("wrap_vec", 32'(bw.vector), 2);
    bf.ack = 1'b1; bw.ack = 1'b1;
    cyc(1);
    bf.ack = 1'b0; bw.ack = 1'b0;
    chk("ch3_ack_irq", 32'(bf.irq), 0);
    chk("ch3_ack_pend", 32'(pend_f), 0);
    cyc(1);
    chk("ch3_idle_irq", 32'(bf.irq), 0);
    chk("held_no_repend", 32'(pend_f), 0);
    lines = '0;
    cyc(1);

    // simultaneous edges on ch1 and ch5
    lines[1] = 1'b1; lines[5] = 1'b1;
    cyc(1);
    chk("c15_pend", 32'(pend_f), 32'h22);
    cyc(1);
    chk("c15_gid1", 32'(bf.grant_id), 1);
    chk("c15_vec1", 32'(bf.vector), 2);
    bf.ack = 1'b1; bw.ack = 1'b1;
    cyc(1);
    bf.ack = 1'b0; bw.ack = 1'b0;
    chk("c15_acked_irq", 32'(bf.irq), 0);
    chk("c15_pend5", 32'(pend_f), 32'h20);
    cyc(2);
    chk("c15_irq5", 32'(bf.irq), 1);
    chk("c15_gid5", 32'(bf.grant_id), 5);
    chk("c15_vec5", 32'(bf.vector), 6);
    bf.ack = 1'b1; bw.ack = 1'b1;
    cyc(1);
    bf.ack = 1'b0; bw.ack = 1'b0;
    chk("c15_pend_clr", 32'(pend_f), 0);
    lines = '0;
    cyc(2);

    // committed request survives mask/enable withdrawal
    lines[4] = 1'b1;
    cyc(2);
    chk("c4_gid", 32'(bf.grant_id), 4);
    chk("c4_vec", 32'(bf.vector), 5);
    msk[4] = 1'b0; gen = 1'b0; lines[4] = 1'b0;
    cyc(2);
    chk("c4_irq_hold", 32'(bf.irq), 1);
    chk("c4_vec_hold", 32'(bf.vector), 5);
    bf.ack = 1'b1; bw.ack = 1'b1;
    cyc(1);
    bf.ack = 1'b0; bw.ack = 1'b0;
    chk("c4_irq_drop", 32'(bf.irq), 0);
    chk("c4_pend_clr", 32'(pend_f), 0);
    msk = 8'hFF; gen = 1'b1;
    cyc(2);

    // spurious ack in IDLE
    bf.ack = 1'b1;
    cyc(1);
    bf.ack = 1'b0;
    chk("spur_set", 32'(spur_f), 1);
    chk("spur_irq", 32'(bf.irq), 0);
    chk("spur_pend", 32'(pend_f), 0);
    cyc(2);
    chk("spur_sticky", 32'(spur_f), 1);
    chk("spur_idle", 32'(bf.irq), 0);

    // reset mid-request drops irq without a clock edge
    lines[2] = 1'b1;
    cyc(2);
    chk("c2_irq", 32'(bf.irq), 1);
    #1 reset = 1'b0;
    #1;
    chk("async_irq", 32'(bf.irq), 0);
    chk("async_spur", 32'(spur_f), 0);
    chk("async_pend", 32'(pend_f), 0);
    lines = '0;
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // round-robin with level ch0 and ch2
    rr_lines[0] = 1'b1; rr_lines[2] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
        cyc(1);
        if (br.irq) seen = 1'b1;
      end
      chk("rr_irq_seen", 32'(seen), 1);
      got = int'(br.grant_id);
      chk($sformatf("rr_grant%0d", n), 32'(got), (n % 2 == 0) ? 0 : 2);
      br.ack = 1'b1;
      cyc(1);
      br.ack = 1'b0;
      chk("rr_level_pend", 32'(pend_r), 32'h05);
    end
    rr_lines = '0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
